// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, requester ids
// and default memory geometry.
package mem_arb_pkg;

    localparam int MEM_ARB_DEPTH_DEFAULT = 64;
    localparam int MEM_ARB_WIDTH_DEFAULT = 32;

    localparam logic REQ_ID_MEM    = 1'b0;
    localparam logic REQ_ID_LOADER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } arb_state_e;

    function automatic logic onehot_to_id(input logic [1:0] grant);
        logic id;
        if (grant[1]) begin
            id = REQ_ID_LOADER;
        end else begin
            id = REQ_ID_MEM;
        end
        return id;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection for two requesters: ptr names the requester that wins a tie.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester always wins, a tie goes to ptr.
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            if (ptr == REQ_ID_LOADER) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port data memory (one access per two cycles).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MEM_ARB_DEPTH_DEFAULT,
    parameter int WIDTH = MEM_ARB_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [WIDTH-1:0] rdata0,
    output logic             err0,

    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata1,
    output logic             err1,

    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] write_data,
    output logic             ctrl_mem_read,
    output logic             ctrl_mem_write,
    input  logic [WIDTH-1:0] read_data
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic             any_req_s;
    logic             arb_s;
    logic             issue_s;
    logic [1:0]       grant_s;
    logic             ptr_s;
    logic             win_id_s;
    logic             sel_we_s;
    logic [WIDTH-1:0] sel_addr_s;
    logic [WIDTH-1:0] sel_wdata_s;
    logic             sel_oor_s;

    logic             id_r;
    logic             we_r;
    logic             oor_r;
    logic [WIDTH-1:0] addr_r;
    logic [WIDTH-1:0] wdata_r;

    logic             gnt0_r;
    logic             gnt1_r;
    logic             mem_rd_r;
    logic             mem_wr_r;
    logic             rvalid0_r;
    logic             rvalid1_r;
    logic             err0_r;
    logic             err1_r;
    logic [WIDTH-1:0] rdata0_r;
    logic [WIDTH-1:0] rdata1_r;

    // Reads update rdata, writes keep it, out-of-range accesses clear it.
    function automatic logic [WIDTH-1:0] next_rdata(
        input logic             hit,
        input logic             oor,
        input logic             we,
        input logic [WIDTH-1:0] mem_val,
        input logic [WIDTH-1:0] cur_val
    );
        logic [WIDTH-1:0] val;
        if (!hit) begin
            val = cur_val;
        end else if (oor) begin
            val = {WIDTH{1'b0}};
        end else if (we) begin
            val = cur_val;
        end else begin
            val = mem_val;
        end
        return val;
    endfunction

    assign any_req_s = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_r;

    // Tie-break pointer: after a grant the other requester is preferred.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r <= REQ_ID_MEM;
        end else if (arb_s) begin
            ptr_r <= ~win_id_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = REQ_ID_MEM;
`endif

    mem_arb_select u_select (
        .req0  (req0),
        .req1  (req1),
        .ptr   (ptr_s),
        .grant (grant_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE:  state_nxt_s = any_req_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = any_req_s ? ST_ISSUE : ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM decode: arb_s marks the edge that captures a winner, issue_s the memory cycle.
    always_comb begin
        arb_s   = 1'b0;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_s   = any_req_s;
                issue_s = 1'b0;
            end
            ST_ISSUE: begin
                arb_s   = 1'b0;
                issue_s = 1'b1;
            end
            ST_RESP: begin
                arb_s   = any_req_s;
                issue_s = 1'b0;
            end
            default: begin
                arb_s   = 1'b0;
                issue_s = 1'b0;
            end
        endcase
    end

    // Route the winning requester's fields toward the capture registers.
    always_comb begin
        win_id_s = onehot_to_id(grant_s);
        if (win_id_s == REQ_ID_LOADER) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        sel_oor_s = (sel_addr_s >= DEPTH_W);
    end

    // Capture the winning access; these registers feed the memory port during ISSUE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_r    <= REQ_ID_MEM;
            we_r    <= 1'b0;
            oor_r   <= 1'b0;
            addr_r  <= {WIDTH{1'b0}};
            wdata_r <= {WIDTH{1'b0}};
        end else if (arb_s) begin
            id_r    <= win_id_s;
            we_r    <= sel_we_s;
            oor_r   <= sel_oor_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
        end else begin
            id_r    <= id_r;
            we_r    <= we_r;
            oor_r   <= oor_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Grant and memory strobes are high only for the ISSUE cycle; out-of-range never strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
        end else begin
            gnt0_r   <= arb_s && grant_s[0];
            gnt1_r   <= arb_s && grant_s[1];
            mem_rd_r <= arb_s && !sel_we_s && !sel_oor_s;
            mem_wr_r <= arb_s && sel_we_s && !sel_oor_s;
        end
    end

    // Response side: the RESP cycle reports the access that just left ISSUE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            rdata0_r  <= {WIDTH{1'b0}};
            rdata1_r  <= {WIDTH{1'b0}};
        end else begin
            rvalid0_r <= issue_s && (id_r == REQ_ID_MEM);
            rvalid1_r <= issue_s && (id_r == REQ_ID_LOADER);
            err0_r    <= issue_s && (id_r == REQ_ID_MEM) && oor_r;
            err1_r    <= issue_s && (id_r == REQ_ID_LOADER) && oor_r;
            rdata0_r  <= next_rdata(issue_s && (id_r == REQ_ID_MEM), oor_r, we_r,
                                    read_data, rdata0_r);
            rdata1_r  <= next_rdata(issue_s && (id_r == REQ_ID_LOADER), oor_r, we_r,
                                    read_data, rdata1_r);
        end
    end

    assign gnt0           = gnt0_r;
    assign gnt1           = gnt1_r;
    assign rvalid0        = rvalid0_r;
    assign rvalid1        = rvalid1_r;
    assign err0           = err0_r;
    assign err1           = err1_r;
    assign rdata0         = rdata0_r;
    assign rdata1         = rdata1_r;
    assign address        = addr_r;
    assign write_data     = wdata_r;
    assign ctrl_mem_read  = mem_rd_r;
    assign ctrl_mem_write = mem_wr_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model. Honours MEM_ARB_ROUND_ROBIN_EN like the design.
module tb_mem_port_arbiter;

    localparam int DEPTH = 64;
    localparam int WIDTH = 32;

    logic        clock;
    logic        reset;
    logic        req0, we0, gnt0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, gnt1, rvalid1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [31:0] address, write_data, read_data;
    logic        ctrl_mem_read, ctrl_mem_write;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    // One cycle of expected behaviour: an issued access, or the response of the previous one.
    typedef struct packed {
        logic        issue;
        logic        id;
        logic        we;
        logic        oor;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rvalid;
        logic [1:0]  err;
    } slot_t;

    slot_t       cur;
    logic [31:0] exp_rdata [2];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_w;
`endif

    mem_port_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .address(address), .write_data(write_data),
        .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
        .read_data(read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'hA5A50000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    assign read_data = (address < 32'(DEPTH)) ? mem[address[5:0]] : 32'h0;

    // Memory behind the arbiter: a write commits at the edge if the strobe is high just before it.
    initial begin
        logic        pend;
        logic [31:0] pa, pd;
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clock);
            #4;
            pend = ctrl_mem_write && (address < 32'(DEPTH));
            pa   = address;
            pd   = write_data;
            @(posedge clock);
            if (pend && reset) mem[pa[5:0]] = pd;
        end
    end

    function automatic logic pick(input logic r0, input logic r1);
        logic w;
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = ~last_w;
`else
            w = 1'b0;
`endif
        end else begin
            w = r1 && !r0;
        end
        return w;
    endfunction

    // A non-ISSUE cycle with any request issues next; an ISSUE cycle is answered next.
    task automatic model_step();
        slot_t nxt;
        logic  w;
        nxt = '0;
        if (cur.issue) begin
            if (cur.oor) exp_rdata[cur.id] = 32'h0;
            else if (cur.we) ref_mem[cur.addr[5:0]] = cur.wdata;
            else exp_rdata[cur.id] = ref_mem[cur.addr[5:0]];
            nxt.rvalid[cur.id] = 1'b1;
            nxt.err[cur.id]    = cur.oor;
        end else if (req0 || req1) begin
            w         = pick(req0, req1);
            nxt.issue = 1'b1;
            nxt.id    = w;
            nxt.we    = w ? we1 : we0;
            nxt.addr  = w ? addr1 : addr0;
            nxt.wdata = w ? wdata1 : wdata0;
            nxt.oor   = (nxt.addr >= 32'(DEPTH));
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_w    = w;
`endif
        end
        cur = nxt;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        cur = '0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_w = 1'b1;
`endif
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                cur = '0;
                exp_rdata[0] = 32'h0;
                exp_rdata[1] = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_w = 1'b1;
`endif
            end else begin
                model_step();
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        logic [1:0] eg;
        forever begin
            @(negedge clock);
            eg = cur.issue ? (cur.id ? 2'b10 : 2'b01) : 2'b00;
            check("gnt0", gnt0, eg[0]);
            check("gnt1", gnt1, eg[1]);
            check("mem_read", ctrl_mem_read, cur.issue && !cur.we && !cur.oor);
            check("mem_write", ctrl_mem_write, cur.issue && cur.we && !cur.oor);
            if (cur.issue) begin
                check("address", address, cur.addr);
                check("write_data", write_data, cur.wdata);
            end else if (!reset) begin
                check("address_rst", address, 32'h0);
                check("write_data_rst", write_data, 32'h0);
            end
            check("rvalid0", rvalid0, cur.rvalid[0]);
            check("rvalid1", rvalid1, cur.rvalid[1]);
            check("err0", err0, cur.err[0]);
            check("err1", err1, cur.err[1]);
            check("rdata0", rdata0, exp_rdata[0]);
            check("rdata1", rdata1, exp_rdata[1]);
        end
    end

    task automatic drive(input int id, input logic rq, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        if (id == 0) begin
            req0 = rq; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One access from requester id: returns response data/err, write-strobe cycles and grant latency.
    task automatic access(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int wr_hi, output int lat);
        logic got;
        drive(id, 1'b1, w, a, d);
        wr_hi = 0;
        lat   = 0;
        got   = 1'b0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clock);
            if (ctrl_mem_write) wr_hi++;
            if ((id == 0) ? gnt0 : gnt1) begin
                got = 1'b1;
                lat = n;
            end
        end
        drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
        check("gnt_seen", got, 1'b1);
        @(negedge clock);
        if (ctrl_mem_write) wr_hi++;
        check("rvalid_resp", (id == 0) ? rvalid0 : rvalid1, 1'b1);
        rd = (id == 0) ? rdata0 : rdata1;
        er = (id == 0) ? err0 : err1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wr_hi, lat, ng, cnt, consec, last_c;
        logic [3:0]  order;
        logic        prev;
        logic        pend [2];
        logic        p_we [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_data [2];

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_mem_write", ctrl_mem_write, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Single read of word 5.
        access(0, 1'b0, 32'd5, 32'h0, rd, er, wr_hi, lat);
        check("single_lat", lat, 32'd1);
        check("single_rdata", rd, 32'hDEADBEEF);
        check("single_err", er, 1'b0);

        // Write then read from requester 1.
        access(1, 1'b1, 32'd10, 32'h12345678, rd, er, wr_hi, lat);
        check("wr_strobe_cycles", wr_hi, 32'd1);
        access(1, 1'b0, 32'd10, 32'h0, rd, er, wr_hi, lat);
        check("wr_rd_rdata", rd, 32'h12345678);
        check("wr_rd_err", er, 1'b0);

        // Contention from a fresh reset.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
        order = 4'b0000;
        ng = 0;
        for (int c = 0; c < 16 && ng < 4; c++) begin
            @(negedge clock);
            if (gnt0 || gnt1) begin
                order[ng] = gnt1;
                ng++;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("contention_count", ng, 32'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("contention_order", order, 4'b1010);
`else
        check("contention_order", order, 4'b0000);
`endif
        repeat (2) @(negedge clock);

        // Out-of-range write.
        access(1, 1'b1, 32'd64, 32'h55AA55AA, rd, er, wr_hi, lat);
        check("oor_wr_strobe", wr_hi, 32'd0);
        check("oor_err", er, 1'b1);
        check("oor_rdata", rd, 32'h0);

        // Reset during the ISSUE cycle of a write to word 3.
        drive(0, 1'b1, 1'b1, 32'd3, 32'hCAFEF00D);
        @(negedge clock);
        check("rst_mid_gnt", gnt0, 1'b1);
        check("rst_mid_wr_before", ctrl_mem_write, 1'b1);
        #2;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rst_mid_wr_drop", ctrl_mem_write, 1'b0);
        check("rst_mid_gnt_drop", gnt0, 1'b0);
        @(negedge clock);
        check("rst_mid_word3", mem[3], 32'hA5A50003);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("rst_mid_no_rvalid", rvalid0, 1'b0);
        end

        // Back-to-back accesses with req0 held.
        drive(0, 1'b1, 1'b0, 32'd7, 32'h0);
        cnt = 0; consec = 0; last_c = 0; prev = 1'b0;
        for (int c = 1; c <= 12 && cnt < 3; c++) begin
            @(negedge clock);
            if (gnt0 && prev) consec++;
            if (gnt0) begin
                if (cnt > 0) check("b2b_gap", c - last_c, 32'd2);
                last_c = c;
                cnt++;
            end
            prev = gnt0;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_count", cnt, 32'd3);
        check("b2b_consecutive", consec, 32'd0);
        repeat (2) @(negedge clock);

        // Random traffic from both requesters with one asynchronous reset pulse.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            p_we[n] = 1'b0; p_addr[n] = 32'h0; p_data[n] = 32'h0;
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (i == 301) reset = 1'b1;
            if (pend[0] && gnt0) pend[0] = 1'b0;
            if (pend[1] && gnt1) pend[1] = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 99) < 55) begin
                    pend[n]   = 1'b1;
                    p_we[n]   = 1'($urandom_range(0, 1));
                    p_addr[n] = 32'($urandom_range(0, 71));
                    p_data[n] = $urandom;
                end
            end
            drive(0, pend[0], p_we[0], p_addr[0], p_data[0]);
            drive(1, pend[1], p_we[1], p_addr[1], p_data[1]);
            if (i == 300) begin
                #2;
                reset = 1'b0;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clock);

        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) cnt++;
        end
        check("mem_final_diff_words", cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of words in the data memory behind the arbiter.
REQ-002 SHALL have parameter WIDTH, default 32: address and data width.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have per-requester ports (n = 0 pipeline MEM stage, n = 1 loader/debug):
- reqN, input, 1: access request.
- weN, input, 1: 1 = write, 0 = read.
- addrN, input, WIDTH: word address.
- wdataN, input, WIDTH: write data.
- gntN, output, 1: request accepted.
- rvalidN, output, 1: response valid.
- rdataN, output, WIDTH: read data.
- errN, output, 1: out-of-range response.
REQ-006 SHALL have memory-side ports:
- address, output, WIDTH.
- write_data, output, WIDTH.
- ctrl_mem_read, output, 1.
- ctrl_mem_write, output, 1.
- read_data, input, WIDTH: combinational memory read data.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE and RESP, with these transitions:
- IDLE -> ISSUE when any req is high.
- ISSUE -> RESP unconditionally.
- RESP -> ISSUE when any req is high, else -> IDLE.
REQ-008 SHALL arbitrate on the clock edge leaving IDLE or RESP, and SHALL capture the winner's id, we, addr and wdata into registers at that edge.
REQ-009 SHALL assert gntN of the winner for exactly the one ISSUE cycle; gnt SHALL never be high for both requesters in the same cycle.
REQ-010 SHALL, in ISSUE, drive address and write_data from the captured registers, with ctrl_mem_write = we and ctrl_mem_read = !we.
REQ-011 SHALL hold ctrl_mem_read and ctrl_mem_write low in every state other than ISSUE.
REQ-012 SHALL capture read_data into the winner's rdata register at the end of ISSUE for reads; for writes, rdata SHALL hold its previous value.
REQ-013 SHALL pulse rvalidN of the winner for exactly the one RESP cycle, for both reads and writes.
REQ-014 SHALL have a grant-to-response latency of 1 cycle; sustained throughput SHALL be one access per 2 cycles.
REQ-015 SHALL treat a request with addr >= DEPTH as out of range:
- ctrl_mem_read and ctrl_mem_write stay low in ISSUE.
- rdata is forced to 0.
- errN = 1 together with rvalidN in RESP.
REQ-016 SHALL require each requester to hold req, we, addr and wdata stable until gnt; a req still high in the cycle after gnt SHALL be treated as a new request.
REQ-017 SHALL NOT modify any rdata register or any memory word for requests that are not granted.

Reset
REQ-018 SHALL, on reset low, immediately force the following regardless of clock:
- FSM state to IDLE.
- gnt*, rvalid* and err* to 0.
- rdata* to 0.
- ctrl_mem_read and ctrl_mem_write to 0.
- address and write_data to 0.
- round-robin pointer to requester 0 (next winner = 0).
REQ-019 SHALL discard any access in progress when reset asserts mid-ISSUE or mid-RESP: no write is committed after reset asserts, and no rvalid pulse follows.
REQ-020 SHALL resume arbitration on the first rising edge after reset deasserts.

Configuration
REQ-021 SHALL compile in round-robin arbitration when macro MEM_ARB_ROUND_ROBIN_EN is defined: on simultaneous requests the winner is the requester not granted most recently, and the pointer updates only on a grant.
REQ-022 SHALL, without MEM_ARB_ROUND_ROBIN_EN, use fixed priority (requester 0 always wins a tie) and SHALL contain no pointer register.

Structure
REQ-023 SHALL take the FSM state encoding (IDLE, ISSUE, RESP), the requester id constants and the default DEPTH/WIDTH values from a shared package, mem_arb_pkg.
REQ-024 SHALL place the winner-selection logic (two requests plus pointer in, one-hot grant out) in a single sub-module, mem_arb_select; all other logic SHALL be flat.

Verification
REQ-025 SHALL have a bench cover these directed scenarios:
- Single read: req0 = 1, we0 = 0, addr0 = 5 with word 5 = 0xDEADBEEF -> gnt0 in cycle 1, rvalid0 in cycle 2, rdata0 = 0xDEADBEEF, err0 = 0.
- Write then read: requester 1 writes 0x12345678 to addr 10, then reads addr 10 -> second response rdata1 = 0x12345678; ctrl_mem_write high for exactly 1 cycle.
- Contention: req0 and req1 high continuously for 4 grants -> with the macro, grant order 0, 1, 0, 1; without it, 0, 0, 0, 0.
- Out of range: req1 = 1, we1 = 1, addr1 = 64 -> ctrl_mem_write never high, rvalid1 = 1 with err1 = 1, memory unchanged.
- Reset mid-access: reset low during the ISSUE cycle of a write to addr 3 -> ctrl_mem_write drops at once, word 3 unchanged, no rvalid, state IDLE.
- Back-to-back: req0 held for 3 accesses -> gnt0 pulses every 2nd cycle, never 2 consecutive cycles.
